// File: rtl/tpumac_pipe.sv
// rtl/tpumac_pipe.sv - LANES-wide signed MAC, multiply stage ahead of accumulate stage.
// Optional TPUMAC_SAT_EN: clamp overflowing accumulates instead of wrapping.
module tpumac_pipe #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int LANES   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       WrEn,
  input  logic                       clr,
  input  logic [LANES*BITS_AB-1:0]   Ain,
  input  logic [LANES*BITS_AB-1:0]   Bin,
  input  logic [LANES*BITS_C-1:0]    Cin,
  output logic [LANES*BITS_AB-1:0]   Aout,
  output logic [LANES*BITS_AB-1:0]   Bout,
  output logic [LANES*BITS_C-1:0]    Cout,
  output logic                       valid_out,
  output logic [LANES-1:0]           ovf
);

  localparam int PW = 2 * BITS_AB;

  logic [LANES*BITS_AB-1:0] a_q, a_d, b_q, b_d;
  logic [LANES*PW-1:0]      p_q, p_d, p_new;
  logic                     pv_q, pv_d;
  logic [LANES*BITS_C-1:0]  c_q, c_d, c_acc;
  logic [LANES-1:0]         ovf_q, ovf_d, add_ovf;
  logic                     valid_q, valid_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [BITS_AB-1:0] a_s, b_s;
    logic signed [PW-1:0]      prod;
    logic signed [BITS_C-1:0]  c_s, p_ext, sum;
    logic                      lane_ovf;

    // Product comes straight from the inputs so it does not wait on Aout/Bout.
    assign a_s   = Ain[i*BITS_AB +: BITS_AB];
    assign b_s   = Bin[i*BITS_AB +: BITS_AB];
    assign prod  = PW'(a_s) * PW'(b_s);
    assign p_new[i*PW +: PW] = prod;

    assign c_s      = c_q[i*BITS_C +: BITS_C];
    assign p_ext    = BITS_C'($signed(p_q[i*PW +: PW]));
    assign sum      = c_s + p_ext;
    assign lane_ovf = (c_s[BITS_C-1] == p_ext[BITS_C-1]) && (sum[BITS_C-1] != c_s[BITS_C-1]);
    assign add_ovf[i] = lane_ovf;

`ifdef TPUMAC_SAT_EN
    // On overflow the true result lies beyond the limit on the operands' side.
    assign c_acc[i*BITS_C +: BITS_C] = !lane_ovf ? sum :
        (c_s[BITS_C-1] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}});
`else
    assign c_acc[i*BITS_C +: BITS_C] = sum;
`endif
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    pv_d    = 1'b0;
    c_d     = c_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (clr) begin
      c_d   = '0;
      ovf_d = '0;
    end else begin
      if (en) begin
        a_d = Ain;
        b_d = Bin;
        if (WrEn) begin
          c_d = Cin;
        end else begin
          p_d  = p_new;
          pv_d = 1'b1;
        end
      end
      // A preload wins over, and discards, the product issued on the previous edge.
      if (pv_q && !(en && WrEn)) begin
        c_d     = c_acc;
        ovf_d   = ovf_q | add_ovf;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      pv_q    <= 1'b0;
      c_q     <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      pv_q    <= pv_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign Aout      = a_q;
  assign Bout      = b_q;
  assign Cout      = c_q;
  assign valid_out = valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_tpumac_pipe.sv
// tb/tb_tpumac_pipe.sv - scoreboard bench for tpumac_pipe against an integer reference model.
module tb_tpumac_pipe;
  localparam int W  = 8;
  localparam int CW = 16;
  localparam int L  = 4;
  localparam int CMAX = 32767;
  localparam int CMIN = -32768;

  logic clk = 1'b0;
  logic rst_n, en, WrEn, clr;
  logic [L*W-1:0]  Ain, Bin, Aout, Bout;
  logic [L*CW-1:0] Cin, Cout;
  logic            valid_out;
  logic [L-1:0]    ovf;

  tpumac_pipe #(.BITS_AB(W), .BITS_C(CW), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .clr(clr),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(Aout), .Bout(Bout), .Cout(Cout), .valid_out(valid_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         v;
    bit [L-1:0] o;
    int         c[L];
    int         a[L];
    int         b[L];
  } rec_t;

  rec_t exp_q[$];
  int checks = 0;
  int failures = 0;

  int sa[L], sb[L], sc[L];
  int m_acc[L], m_a[L], m_b[L], m_prod[L];
  bit [L-1:0] m_ovf;
  bit m_issued;

  task automatic check(input string nm, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, expv, $time);
    end
  endtask

  function automatic int fit(input int x, output bit of);
    of = (x > CMAX) || (x < CMIN);
`ifdef TPUMAC_SAT_EN
    if (x > CMAX) return CMAX;
    if (x < CMIN) return CMIN;
    return x;
`else
    return int'(shortint'(x));
`endif
  endfunction

  function automatic int lane_c(input int i);
    return int'($signed(Cout[i*CW +: CW]));
  endfunction

  function automatic int lane_a(input int i);
    return int'($signed(Aout[i*W +: W]));
  endfunction

  function automatic int lane_b(input int i);
    return int'($signed(Bout[i*W +: W]));
  endfunction

  // Drive one cycle at the negedge, advance the model across the coming edge, queue the expectation.
  task automatic do_cycle(input bit e, input bit w, input bit c);
    rec_t r;
    bit of;
    @(negedge clk);
    en = e; WrEn = w; clr = c;
    for (int i = 0; i < L; i++) begin
      Ain[i*W +: W]   = W'(sa[i]);
      Bin[i*W +: W]   = W'(sb[i]);
      Cin[i*CW +: CW] = CW'(sc[i]);
    end
    r.v = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < L; i++) begin
        m_acc[i] = 0; m_a[i] = 0; m_b[i] = 0;
      end
      m_ovf = '0;
      m_issued = 1'b0;
    end else if (c) begin
      for (int i = 0; i < L; i++) m_acc[i] = 0;
      m_ovf = '0;
      m_issued = 1'b0;
    end else if (e && w) begin
      for (int i = 0; i < L; i++) begin
        m_acc[i] = sc[i]; m_a[i] = sa[i]; m_b[i] = sb[i];
      end
      m_issued = 1'b0;
    end else begin
      r.v = m_issued;
      if (m_issued) begin
        for (int i = 0; i < L; i++) begin
          m_acc[i] = fit(m_acc[i] + m_prod[i], of);
          if (of) m_ovf[i] = 1'b1;
        end
      end
      if (e) begin
        for (int i = 0; i < L; i++) begin
          m_a[i] = sa[i]; m_b[i] = sb[i]; m_prod[i] = sa[i] * sb[i];
        end
      end
      m_issued = e;
    end
    r.o = m_ovf;
    for (int i = 0; i < L; i++) begin
      r.c[i] = m_acc[i]; r.a[i] = m_a[i]; r.b[i] = m_b[i];
    end
    exp_q.push_back(r);
  endtask

  task automatic chk_now(input string nm, input int lane, input int expv);
    @(posedge clk);
    #2;
    check(nm, lane_c(lane), expv);
  endtask

  task automatic set_ops(input int a0, input int b0, input int c0);
    for (int i = 0; i < L; i++) begin
      sa[i] = 0; sb[i] = 0; sc[i] = 0;
    end
    sa[0] = a0; sb[0] = b0; sc[0] = c0;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < L; i++) begin
      sa[i] = int'($urandom_range(0, 255)) - 128;
      sb[i] = int'($urandom_range(0, 255)) - 128;
      sc[i] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin
    rec_t r;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("valid_out", int'(valid_out), int'(r.v));
        check("ovf", int'(ovf), int'(r.o));
        for (int i = 0; i < L; i++) begin
          check($sformatf("Cout[%0d]", i), lane_c(i), r.c[i]);
          check($sformatf("Aout[%0d]", i), lane_a(i), r.a[i]);
          check($sformatf("Bout[%0d]", i), lane_b(i), r.b[i]);
        end
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; WrEn = 1'b0; clr = 1'b0;
    Ain = '0; Bin = '0; Cin = '0;
    set_ops(0, 0, 0);
    for (int i = 0; i < L; i++) begin
      m_acc[i] = 0; m_a[i] = 0; m_b[i] = 0; m_prod[i] = 0;
    end
    m_ovf = '0;
    m_issued = 1'b0;
    #17;
    check("reset Cout", int'(Cout != '0), 0);
    check("reset valid", int'(valid_out), 0);
    check("reset ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload on lanes 0 and 3
    set_ops(3, 5, 100);
    sa[3] = -2; sb[3] = 9; sc[3] = -7;
    do_cycle(1, 1, 0);
    chk_now("load lane3", 3, -7);

    // Latency: 100 + (-4*7)
    set_ops(-4, 7, 0);
    do_cycle(1, 0, 0);
    chk_now("latency +1", 0, 100);
    do_cycle(0, 0, 0);
    chk_now("latency +2", 0, 72);
    do_cycle(0, 0, 0);

    // Streaming
    set_ops(0, 0, 0);
    do_cycle(1, 1, 0);
    set_ops(2, 3, 0);  do_cycle(1, 0, 0);
    set_ops(4, 5, 0);  do_cycle(1, 0, 0);
    set_ops(-1, 6, 0); do_cycle(1, 0, 0);
    do_cycle(0, 0, 0);
    chk_now("stream", 0, 20);

    // Overflow, then clear
    set_ops(0, 0, CMAX);
    do_cycle(1, 1, 0);
    set_ops(1, 1, 0);
    do_cycle(1, 0, 0);
    do_cycle(0, 0, 0);
`ifdef TPUMAC_SAT_EN
    chk_now("ovf sat", 0, CMAX);
`else
    chk_now("ovf wrap", 0, CMIN);
`endif
    check("ovf lanes", int'(ovf), 1);
    do_cycle(0, 0, 1);
    chk_now("clr Cout", 0, 0);
    check("clr ovf", int'(ovf), 0);

    // Squash by preload, then by clear
    set_ops(0, 0, 0);  do_cycle(1, 1, 0);
    set_ops(10, 10, 0); do_cycle(1, 0, 0);
    set_ops(0, 0, 50); do_cycle(1, 1, 0);
    do_cycle(0, 0, 0);
    do_cycle(0, 0, 0);
    chk_now("squash wren", 0, 50);
    set_ops(0, 0, 0);  do_cycle(1, 1, 0);
    set_ops(10, 10, 0); do_cycle(1, 0, 0);
    do_cycle(0, 0, 1);
    do_cycle(0, 0, 0);
    chk_now("squash clr", 0, 0);

    // Async reset with a product in flight
    set_ops(0, 0, 500); do_cycle(1, 1, 0);
    set_ops(20, 20, 0); do_cycle(1, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async Cout", int'(Cout != '0), 0);
    check("async Aout", int'(Aout != '0 || Bout != '0), 0);
    check("async valid", int'(valid_out), 0);
    check("async ovf", int'(ovf), 0);
    randomize_ops();
    do_cycle(1, 0, 0);
    do_cycle(1, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    set_ops(3, 3, 0);
    do_cycle(1, 0, 0);
    do_cycle(0, 0, 0);
    chk_now("post reset", 0, 9);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bit e, w, c;
      randomize_ops();
      e = ($urandom_range(0, 99) < 75);
      w = ($urandom_range(0, 99) < 10);
      c = ($urandom_range(0, 99) < 4);
      do_cycle(e, w, c);
    end
    do_cycle(0, 0, 0);
    do_cycle(0, 0, 0);
    @(posedge clk);
    #3;
    check("scoreboard drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
